// File: rtl/add_pkg.sv
// Shared types and default widths for the
// pipelined adder/accumulator.
package add_pkg;

  typedef enum logic {
    ADD_M = 1'b0,
    ACC_M = 1'b1
  } add_mode_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_ACC_W = 8;

endpackage

// File: rtl/add_acc_if.sv
// Producer/consumer handshake bundle for
// the adder/accumulator.
interface add_acc_if
  import add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = DEF_ACC_W
) (
  input logic clk,
  input logic rst_n
);

  logic             in_valid;
  logic             in_ready;
  add_mode_t        mode;
  logic             clr;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] sum;
  logic             ovf;

  modport dut (
    input  in_valid, mode, clr, a, b,
    input  out_ready,
    output in_ready, out_valid, sum, ovf
  );

  modport drv (
    input  clk, rst_n,
    output in_valid, mode, clr, a, b,
    output out_ready,
    input  in_ready, out_valid, sum, ovf
  );

  modport mon (
    input clk, rst_n,
    input in_valid, mode, clr, a, b,
    input out_ready,
    input in_ready, out_valid, sum, ovf
  );

endinterface

// File: rtl/add_acc_core.sv
// Combinational next-state for one accepted
// ADD or ACC operation.
module add_acc_core
  import add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = DEF_ACC_W
) (
  input  add_mode_t        mode,
  input  logic             clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [ACC_W-1:0] acc,
  input  logic             ovf,
  output logic [ACC_W-1:0] next_sum,
  output logic [ACC_W-1:0] next_acc,
  output logic             next_ovf
);

  logic [WIDTH:0]   add_s;
  logic [ACC_W-1:0] base;
  logic             ovf_base;
  logic [ACC_W:0]   acc_s;

  // ADD is sized one bit wider than the operands so it never wraps
  assign add_s    = (WIDTH+1)'(a) + (WIDTH+1)'(b);
  assign base     = clr ? '0 : acc;
  assign ovf_base = clr ? 1'b0 : ovf;
  assign acc_s    = (ACC_W+1)'(base) + (ACC_W+1)'(a);

  always_comb begin
    next_sum = ACC_W'(add_s);
    next_acc = base;
    next_ovf = ovf_base;
    unique case (mode)
      ACC_M: begin
        next_sum = acc_s[ACC_W-1:0];
        next_acc = acc_s[ACC_W-1:0];
        next_ovf = ovf_base | acc_s[ACC_W];
      end
      ADD_M: begin
        next_sum = ACC_W'(add_s);
      end
      default: begin
        next_sum = ACC_W'(add_s);
      end
    endcase
  end

endmodule

// File: rtl/add_acc_pipe.sv
// Registered adder/accumulator with a single
// output register and valid/ready on both sides.
module add_acc_pipe
  import add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = DEF_ACC_W
) (
  input logic    clk,
  input logic    rst_n,
  add_acc_if.dut bus
);

  if (ACC_W < WIDTH + 1) begin : g_bad_w
    $fatal(1, "add_acc_pipe: ACC_W must be >= WIDTH+1");
  end

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum_q;
  logic             ovf_q;
  logic             vld_q;
  logic [ACC_W-1:0] next_sum;
  logic [ACC_W-1:0] next_acc;
  logic             next_ovf;
  logic             accept;

  add_acc_core #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_core (
    .mode     (bus.mode),
    .clr      (bus.clr),
    .a        (bus.a),
    .b        (bus.b),
    .acc      (acc),
    .ovf      (ovf_q),
    .next_sum (next_sum),
    .next_acc (next_acc),
    .next_ovf (next_ovf)
  );

  assign bus.in_ready  = !vld_q || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = vld_q;
  assign bus.sum       = sum_q;
  assign bus.ovf       = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      sum_q <= '0;
      ovf_q <= 1'b0;
      vld_q <= 1'b0;
    end else if (accept) begin
      acc   <= next_acc;
      sum_q <= next_sum;
      ovf_q <= next_ovf;
      vld_q <= 1'b1;
    end else if (bus.out_ready) begin
      vld_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_acc_pipe.sv
// Directed and streamed checks for
// add_acc_pipe at WIDTH=4, ACC_W=8.
module tb_add_acc_pipe;
  import add_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  add_acc_if #(.WIDTH(4), .ACC_W(8)) bus (
    .clk   (clk),
    .rst_n (rst_n)
  );

  add_acc_pipe #(.WIDTH(4), .ACC_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d want %0d",
             tag, obs, exp);
    end
  endtask

  task automatic op(input add_mode_t m,
                    input logic c,
                    input int av,
                    input int bv);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.mode      = m;
    bus.clr       = c;
    bus.a         = 4'(av);
    bus.b         = 4'(bv);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.clr      = 1'b0;
  endtask

  int q_sum[$];
  int q_ovf[$];
  int m_acc;
  int m_ovf;
  int n_acc;
  int n_del;
  int nx;
  int e_sum;
  int e_ovf;
  int cyc;

  initial begin
    tests         = 0;
    fails         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.mode      = ADD_M;
    bus.clr       = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_sum", int'(bus.sum), 0);
    chk("rst_ovf", int'(bus.ovf), 0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", int'(bus.in_ready), 1);

    // 1: back-to-back adds
    op(ADD_M, 1'b0, 4, 4);
    chk("add1_sum", int'(bus.sum), 8);
    chk("add1_vld", int'(bus.out_valid), 1);
    op(ADD_M, 1'b0, 3, 4);
    chk("add2_sum", int'(bus.sum), 7);
    op(ADD_M, 1'b0, 3, 7);
    chk("add3_sum", int'(bus.sum), 10);
    chk("add3_ovf", int'(bus.ovf), 0);

    // 2: widest add does not wrap
    op(ADD_M, 1'b0, 15, 15);
    chk("add_max_sum", int'(bus.sum), 30);
    chk("add_max_ovf", int'(bus.ovf), 0);

    // 3: accumulate to wrap, sticky ovf, clear
    op(ACC_M, 1'b1, 15, 0);
    chk("acc_clr_sum", int'(bus.sum), 15);
    for (int i = 0; i < 16; i++)
      op(ACC_M, 1'b0, 15, 9);
    chk("acc_255_sum", int'(bus.sum), 255);
    chk("acc_255_ovf", int'(bus.ovf), 0);
    op(ACC_M, 1'b0, 1, 0);
    chk("acc_wrap_sum", int'(bus.sum), 0);
    chk("acc_wrap_ovf", int'(bus.ovf), 1);
    op(ACC_M, 1'b0, 2, 0);
    chk("acc_stick_sum", int'(bus.sum), 2);
    chk("acc_stick_ovf", int'(bus.ovf), 1);
    op(ADD_M, 1'b0, 1, 1);
    chk("add_keep_ovf", int'(bus.ovf), 1);
    op(ACC_M, 1'b1, 5, 0);
    chk("acc_clr2_sum", int'(bus.sum), 5);
    chk("acc_clr2_ovf", int'(bus.ovf), 0);

    // 4: back-pressure with a pending input
    op(ADD_M, 1'b0, 4, 4);
    chk("bp_first", int'(bus.sum), 8);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.mode      = ADD_M;
    bus.a         = 4'd1;
    bus.b         = 4'd2;
    #1;
    chk("bp_inrdy", int'(bus.in_ready), 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_sum", int'(bus.sum), 8);
      chk("bp_hold_vld", int'(bus.out_valid), 1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", int'(bus.in_ready), 1);
    chk("bp_deliver_old", int'(bus.sum), 8);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("bp_new_sum", int'(bus.sum), 3);
    chk("bp_new_vld", int'(bus.out_valid), 1);
    @(posedge clk);
    #1;
    chk("bp_drained", int'(bus.out_valid), 0);

    // 5: random streaming vs reference model
    m_acc = 5;
    m_ovf = 0;
    n_acc = 0;
    n_del = 0;
    cyc   = 0;
    bus.in_valid = 1'b0;
    while ((n_acc < 200 || q_sum.size() > 0)
           && cyc < 3000) begin
      if (!bus.in_valid && n_acc < 200) begin
        bus.in_valid = 1'b1;
        bus.mode = add_mode_t'($urandom_range(0, 1));
        bus.clr  = ($urandom_range(0, 7) == 0);
        bus.a    = 4'($urandom_range(0, 15));
        bus.b    = 4'($urandom_range(0, 15));
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      #3;
      if (bus.out_valid && bus.out_ready) begin
        if (q_sum.size() == 0) begin
          chk("str_extra", 1, 0);
        end else begin
          chk("str_sum", int'(bus.sum), q_sum.pop_front());
          chk("str_ovf", int'(bus.ovf), q_ovf.pop_front());
        end
        n_del++;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (bus.clr) begin
          m_acc = 0;
          m_ovf = 0;
        end
        if (bus.mode == ACC_M) begin
          nx    = m_acc + int'(bus.a);
          m_acc = nx % 256;
          if (nx > 255) m_ovf = 1;
          e_sum = m_acc;
        end else begin
          e_sum = int'(bus.a) + int'(bus.b);
        end
        e_ovf = m_ovf;
        q_sum.push_back(e_sum);
        q_ovf.push_back(e_ovf);
        n_acc++;
      end
      @(posedge clk);
      #1;
      if (bus.in_valid && n_acc > 0 && !bus.in_ready) begin
      end
      if (n_acc >= 200) bus.in_valid = 1'b0;
      else if (bus.in_valid) begin
        // an op is consumed once its accept edge has passed
        bus.in_valid = 1'b0;
        bus.clr      = 1'b0;
      end
      cyc++;
    end
    chk("str_timeout", int'(cyc < 3000), 1);
    chk("str_count", n_del, n_acc);
    chk("str_accepts", n_acc, 200);

    // 6: asynchronous reset mid-accumulation
    op(ACC_M, 1'b1, 10, 0);
    for (int i = 0; i < 6; i++)
      op(ACC_M, 1'b0, 15, 0);
    chk("pre_rst_sum", int'(bus.sum), 100);
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", int'(bus.out_valid), 0);
    chk("arst_sum", int'(bus.sum), 0);
    chk("arst_ovf", int'(bus.ovf), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("arst_rdy", int'(bus.in_ready), 1);
    op(ACC_M, 1'b0, 1, 0);
    chk("post_rst_sum", int'(bus.sum), 1);
    chk("post_rst_ovf", int'(bus.ovf), 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
